// File: rtl/mio_bus.sv
// CPU-side memory/IO bus bridge: one access at a time, RAM latency fixed, IO completion on io_ack.
// Optional IO watchdog enabled by defining MIO_TIMEOUT_EN (absent: IO waits indefinitely, bus_err tied 0).
module mio_bus #(
  parameter int RAM_LAT = 2,
  parameter int IO_TMO  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        CPU_MIO,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        ram_we,
  output logic [7:0]  io_addr,
  output logic [31:0] io_wdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        bus_err
);

  if (RAM_LAT < 1 || RAM_LAT > 7 || IO_TMO < 2 || IO_TMO > 255) begin : g_bad_param
    $error("mio_bus: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, DONE} state_t;

  localparam logic [2:0] RAM_LAST = 3'(RAM_LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic [2:0]  r_cnt;
  logic [31:0] r_data;

  logic w_req;
  logic w_is_io;
  logic w_start;
  logic w_ram_last;
  logic w_io_done;
  logic w_tmo_hit;

  assign w_req      = CPU_MIO & (MemRead | MemWrite);
  assign w_is_io    = (Addr_in[31:28] == 4'hF);
  assign w_start    = (r_state == IDLE) & w_req;
  assign w_ram_last = (r_state == RAM_WAIT) & (r_cnt == RAM_LAST);
  assign w_io_done  = (r_state == IO_WAIT) & io_ack;

`ifdef MIO_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(IO_TMO - 1);

  logic [7:0] r_tmo;
  logic       r_bus_err;

  // io_ack in the final watchdog cycle wins over the timeout.
  assign w_tmo_hit = (r_state == IO_WAIT) & ~io_ack & (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_start)
        r_tmo <= '0;
      else if (r_state == IO_WAIT)
        r_tmo <= r_tmo + 8'd1;
      if (w_tmo_hit)
        r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_tmo_hit = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    MIO_ready   = 1'b0;
    ram_we      = 1'b0;
    io_rd       = 1'b0;
    io_wr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req)
          w_state_nxt = w_is_io ? IO_WAIT : RAM_WAIT;
      end
      RAM_WAIT: begin
        ram_we = r_wr & (r_cnt == 3'd0);
        if (w_ram_last)
          w_state_nxt = DONE;
      end
      IO_WAIT: begin
        io_rd = ~r_wr;
        io_wr = r_wr;
        if (w_io_done || w_tmo_hit)
          w_state_nxt = DONE;
      end
      DONE: begin
        MIO_ready   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once so the CPU may change its inputs mid-access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_start) begin
        r_addr  <= Addr_in[11:2];
        r_wdata <= Data_in;
        r_wr    <= MemWrite;
        r_cnt   <= '0;
      end else if (r_state == RAM_WAIT) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_data <= '0;
    else if (!r_wr) begin
      if (w_ram_last)
        r_data <= ram_dout;
      else if (w_io_done)
        r_data <= io_rdata;
      else if (w_tmo_hit)
        r_data <= 32'hDEADBEEF;
    end
  end

  assign Data_out = r_data;
  assign ram_addr = r_addr;
  assign ram_din  = r_wdata;
  assign io_addr  = r_addr[7:0];
  assign io_wdata = r_wdata;

endmodule

// File: tb/tb_mio_bus.sv
// Bench for mio_bus: directed scenarios plus randomized RAM/IO traffic against a word-array model.
`timescale 1ns/1ps
module tb_mio_bus;
  localparam int RAM_LAT = 2;
  localparam int IO_TMO  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, CPU_MIO = 1'b0;
  logic [31:0] Addr_in = '0, Data_in = '0;
  logic [31:0] Data_out;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_we;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic        io_rd, io_wr;
  logic [31:0] io_rdata = '0;
  logic        io_ack = 1'b0;
  logic        bus_err;

  always #5 clk = ~clk;

  mio_bus #(.RAM_LAT(RAM_LAT), .IO_TMO(IO_TMO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
    .Addr_in(Addr_in), .Data_in(Data_in), .Data_out(Data_out), .MIO_ready(MIO_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .ram_we(ram_we),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr),
    .io_rdata(io_rdata), .io_ack(io_ack), .bus_err(bus_err)
  );

  logic [31:0] ram_mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_model [0:1023];
  logic [31:0] exp_data = '0;

  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                        input int ack_dly, input logic [31:0] io_data,
                        output int lat, output int we_cnt, output logic [9:0] we_addr,
                        output logic [31:0] we_din, output int rd_cnt, output int wr_cnt,
                        output logic [7:0] io_a, output logic [31:0] io_wd,
                        output logic strobe_done, output logic rdy_after);
    we_cnt = 0; rd_cnt = 0; wr_cnt = 0; we_addr = '0; we_din = '0; io_a = '0; io_wd = '0;
    Addr_in = a; Data_in = d; MemRead = rd; MemWrite = wr; CPU_MIO = 1'b1; io_rdata = io_data;
    @(posedge clk); #1;
    CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    lat = 1;
    while (!MIO_ready && lat <= 200) begin
      if (ram_we) begin we_cnt++; we_addr = ram_addr; we_din = ram_din; end
      if (io_rd) rd_cnt++;
      if (io_wr) begin wr_cnt++; io_wd = io_wdata; end
      if (io_rd || io_wr) io_a = io_addr;
      io_ack = (ack_dly >= 0 && lat - 1 == ack_dly);
      @(posedge clk); #1;
      lat++;
    end
    io_ack = 1'b0;
    if (lat > 200) lat = -1;
    strobe_done = io_rd | io_wr;
    @(posedge clk); #1;
    rdy_after = MIO_ready;
  endtask

  int lat, we_cnt, rd_cnt, wr_cnt;
  logic [9:0] we_addr;
  logic [31:0] we_din, io_wd;
  logic [7:0] io_a;
  logic strobe_done, rdy_after;

  task automatic test_reset();
    CPU_MIO = 1'b1; MemWrite = 1'b1; Addr_in = 32'h40; Data_in = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({MIO_ready, ram_we, io_rd, io_wr, bus_err} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {MIO_ready, ram_we, io_rd, io_wr, bus_err}); end
    checks++; if (Data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", Data_out); end
    checks++; if (ram_addr !== 10'h0 || io_addr !== 8'h0) begin errors++;
      $display("FAIL reset_addr: ram %h io %h want 0", ram_addr, io_addr); end
    checks++; if (ram_din !== 32'h0 || io_wdata !== 32'h0) begin errors++;
      $display("FAIL reset_wdata: ram %h io %h want 0", ram_din, io_wdata); end
    CPU_MIO = 1'b0; MemWrite = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (MIO_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready: got %b want 0", MIO_ready); end
  endtask

  task automatic test_ram_directed();
    access(32'h10, 32'h12345678, 0, 1, -1, 0, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    mem_model[4] = 32'h12345678;
    checks++; if (lat != RAM_LAT + 1) begin errors++; $display("FAIL ram_wr_lat: got %0d want %0d", lat, RAM_LAT + 1); end
    checks++; if (we_cnt != 1 || we_addr !== 10'd4 || we_din !== 32'h12345678) begin errors++;
      $display("FAIL ram_wr_pulse: cnt %0d addr %0d din %h want 1/4/12345678", we_cnt, we_addr, we_din); end
    checks++; if (Data_out !== exp_data) begin errors++; $display("FAIL ram_wr_dout: got %h want %h", Data_out, exp_data); end
    access(32'h10, 32'h0, 1, 0, -1, 0, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    exp_data = mem_model[4];
    checks++; if (lat != RAM_LAT + 1) begin errors++; $display("FAIL ram_rd_lat: got %0d want %0d", lat, RAM_LAT + 1); end
    checks++; if (Data_out !== exp_data) begin errors++; $display("FAIL ram_rd_data: got %h want %h", Data_out, exp_data); end
    checks++; if (we_cnt != 0 || rdy_after !== 1'b0) begin errors++;
      $display("FAIL ram_rd_misc: we_cnt %0d rdy_after %b want 0/0", we_cnt, rdy_after); end
  endtask

  task automatic test_io_read();
    access(32'hF0000004, 32'h0, 1, 0, 3, 32'hA5A5A5A5, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    exp_data = 32'hA5A5A5A5;
    checks++; if (io_a !== 8'd1) begin errors++; $display("FAIL io_rd_addr: got %0d want 1", io_a); end
    checks++; if (Data_out !== exp_data) begin errors++; $display("FAIL io_rd_data: got %h want %h", Data_out, exp_data); end
    checks++; if (lat != 5) begin errors++; $display("FAIL io_rd_lat: got %0d want 5", lat); end
    checks++; if (rd_cnt != 4 || strobe_done !== 1'b0) begin errors++;
      $display("FAIL io_rd_strobe: high %0d cycles, in DONE %b; want 4/0", rd_cnt, strobe_done); end
    checks++; if (rdy_after !== 1'b0 || we_cnt != 0) begin errors++;
      $display("FAIL io_rd_pulse: rdy_after %b we_cnt %0d want 0/0", rdy_after, we_cnt); end
  endtask

  task automatic test_rw_both();
    access(32'h8, 32'hCAFEF00D, 1, 1, -1, 0, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    mem_model[2] = 32'hCAFEF00D;
    checks++; if (we_cnt != 1 || we_addr !== 10'd2) begin errors++;
      $display("FAIL both_we: cnt %0d addr %0d want 1/2", we_cnt, we_addr); end
    checks++; if (Data_out !== exp_data) begin errors++; $display("FAIL both_dout: got %h want %h", Data_out, exp_data); end
    access(32'h8, 32'h0, 1, 0, -1, 0, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    exp_data = mem_model[2];
    checks++; if (Data_out !== exp_data) begin errors++; $display("FAIL both_readback: got %h want %h", Data_out, exp_data); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, iod;
    int op, dly, exp_lat, exp_we, exp_rd, exp_wr;
    bit is_io, wr;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; d = $urandom; iod = $urandom;
      op = $urandom_range(0, 2); dly = $urandom_range(0, 5);
      if ($urandom_range(0, 2) == 0) a[31:28] = 4'hF;
      else if (a[31:28] == 4'hF) a[31:28] = 4'h0;
      is_io = (a[31:28] == 4'hF);
      wr = (op != 0);
      access(a, d, op != 1, op != 0, dly, iod, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
      exp_lat = is_io ? dly + 2 : RAM_LAT + 1;
      exp_we  = (!is_io && wr) ? 1 : 0;
      exp_rd  = (is_io && !wr) ? dly + 1 : 0;
      exp_wr  = (is_io && wr) ? dly + 1 : 0;
      if (!is_io && wr) mem_model[a[11:2]] = d;
      if (!wr) exp_data = is_io ? iod : mem_model[a[11:2]];
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_lat: got %0d want %0d", i, lat, exp_lat); end
      checks++; if (Data_out !== exp_data) begin errors++; $display("FAIL rnd%0d_data: got %h want %h", i, Data_out, exp_data); end
      checks++; if (we_cnt != exp_we || rd_cnt != exp_rd || wr_cnt != exp_wr) begin errors++;
        $display("FAIL rnd%0d_strobes: we %0d rd %0d wr %0d want %0d/%0d/%0d", i, we_cnt, rd_cnt, wr_cnt, exp_we, exp_rd, exp_wr); end
      if (is_io) begin
        checks++; if (io_a !== a[9:2]) begin errors++; $display("FAIL rnd%0d_ioaddr: got %h want %h", i, io_a, a[9:2]); end
      end
      if (is_io && wr) begin
        checks++; if (io_wd !== d) begin errors++; $display("FAIL rnd%0d_iowdata: got %h want %h", i, io_wd, d); end
      end
      if (exp_we == 1) begin
        checks++; if (we_addr !== a[11:2] || we_din !== d) begin errors++;
          $display("FAIL rnd%0d_ramwr: addr %h din %h want %h/%h", i, we_addr, we_din, a[11:2], d); end
      end
      checks++; if (rdy_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_pulse: rdy_after %b want 0", i, rdy_after); end
    end
  endtask

  task automatic test_back_to_back();
    int pulses, first;
    pulses = 0; first = -1;
    Addr_in = 32'h10; MemRead = 1'b1; MemWrite = 1'b0; CPU_MIO = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (MIO_ready) begin pulses++; if (first < 0) first = c; end
    end
    CPU_MIO = 1'b0; MemRead = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_data = mem_model[4];
    checks++; if (pulses != 3 || first != RAM_LAT + 1) begin errors++;
      $display("FAIL b2b_pulses: count %0d first %0d want 3/%0d", pulses, first, RAM_LAT + 1); end
    checks++; if (Data_out !== exp_data) begin errors++; $display("FAIL b2b_data: got %h want %h", Data_out, exp_data); end
  endtask

`ifdef MIO_TIMEOUT_EN
  task automatic test_timeout();
    access(32'hF0000020, 32'h0, 1, 0, IO_TMO - 1, 32'h5A5A0001, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    exp_data = 32'h5A5A0001;
    checks++; if (Data_out !== exp_data || bus_err !== 1'b0) begin errors++;
      $display("FAIL tmo_ack_wins: data %h err %b want %h/0", Data_out, bus_err, exp_data); end
    access(32'hF0000004, 32'h0, 1, 0, -1, 32'h11111111, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    exp_data = 32'hDEADBEEF;
    checks++; if (lat != IO_TMO + 1 || rd_cnt != IO_TMO) begin errors++;
      $display("FAIL tmo_lat: lat %0d strobe %0d want %0d/%0d", lat, rd_cnt, IO_TMO + 1, IO_TMO); end
    checks++; if (Data_out !== exp_data || bus_err !== 1'b1) begin errors++;
      $display("FAIL tmo_result: data %h err %b want DEADBEEF/1", Data_out, bus_err); end
    access(32'h10, 32'h0, 1, 0, -1, 0, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    exp_data = mem_model[4];
    checks++; if (bus_err !== 1'b1 || Data_out !== exp_data) begin errors++;
      $display("FAIL tmo_sticky: err %b data %h want 1/%h", bus_err, Data_out, exp_data); end
  endtask
`endif

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    Addr_in = 32'hF0000008; MemRead = 1'b1; CPU_MIO = 1'b1;
    @(posedge clk); #1;
    CPU_MIO = 1'b0; MemRead = 1'b0;
    checks++; if (io_rd !== 1'b1) begin errors++; $display("FAIL mid_strobe_up: io_rd %b want 1", io_rd); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (io_rd !== 1'b0 || MIO_ready !== 1'b0) begin errors++;
      $display("FAIL mid_abort: io_rd %b ready %b want 0/0", io_rd, MIO_ready); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (MIO_ready) pulses++;
    end
    reset = 1'b1;
    exp_data = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (MIO_ready) pulses++;
    end
    checks++; if (pulses != 0 || bus_err !== 1'b0 || Data_out !== exp_data) begin errors++;
      $display("FAIL mid_quiet: pulses %0d err %b data %h want 0/0/0", pulses, bus_err, Data_out); end
    access(32'h10, 32'h0, 1, 0, -1, 0, lat, we_cnt, we_addr, we_din, rd_cnt, wr_cnt, io_a, io_wd, strobe_done, rdy_after);
    exp_data = mem_model[4];
    checks++; if (lat != RAM_LAT + 1 || Data_out !== exp_data) begin errors++;
      $display("FAIL mid_recover: lat %0d data %h want %0d/%h", lat, Data_out, RAM_LAT + 1, exp_data); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ram_mem[i] = '0; mem_model[i] = '0; end
    test_reset();
    test_ram_directed();
    test_io_read();
    test_rw_both();
    test_random();
    test_back_to_back();
`ifdef MIO_TIMEOUT_EN
    test_timeout();
`else
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL no_tmo_err: got %b want 0", bus_err); end
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
